spi_txn_scheduler: RTL

SPI_TXN_SCHEDULER -- requirements
Module: spi_txn_scheduler

---
 rtl/spi_pkg.sv | 19 +
 rtl/spi_txn_scheduler_if.sv | 34 +++
 rtl/spi_rr_arbiter.sv | 26 ++
 rtl/spi_txn_scheduler.sv | 138 +++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transaction scheduler.
//   BYTE_W       : width of one SPI byte
//   GAP_CYC_DEF  : default idle cycles between bytes of one transaction
//   TO_CYC_DEF   : default watchdog limit for one engine wait
//   state_t      : scheduler FSM encoding
package spi_pkg;
  localparam int BYTE_W      = 8;
  localparam int GAP_CYC_DEF = 2;
  localparam int TO_CYC_DEF  = 64;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    LOAD,
    WAIT_BUSY,
    WAIT_DONE,
    GAP
  } state_t;
endpackage

// File: rtl/spi_txn_scheduler_if.sv
// Bundle of the requester-side and byte-engine-side signals of the scheduler.
//   slave  : scheduler view (requests, MOSI bytes and engine status in;
//            grants, takes, MISO results and engine strobe out)
//   master : environment view (requesters + byte engine), directions mirrored
interface spi_txn_scheduler_if #(parameter int LEN_W = 4);
  import spi_pkg::*;

  logic [1:0]          req_valid;
  logic [2*LEN_W-1:0]  req_len;
  logic [1:0]          req_grant;
  logic [2*BYTE_W-1:0] tx_data;
  logic [1:0]          tx_take;
  logic [BYTE_W-1:0]   rx_data;
  logic                rx_valid;
  logic                rx_id;
  logic                txn_done;
  logic                txn_err;
  logic                eng_nwr;
  logic [BYTE_W-1:0]   eng_data_tx;
  logic [BYTE_W-1:0]   eng_data_rx;
  logic                eng_busy;

  modport slave (
    input  req_valid, req_len, tx_data, eng_data_rx, eng_busy,
    output req_grant, tx_take, rx_data, rx_valid, rx_id, txn_done, txn_err,
           eng_nwr, eng_data_tx
  );

  modport master (
    output req_valid, req_len, tx_data, eng_data_rx, eng_busy,
    input  req_grant, tx_take, rx_data, rx_valid, rx_id, txn_done, txn_err,
           eng_nwr, eng_data_tx
  );
endinterface

// File: rtl/spi_rr_arbiter.sv
// Two-way round-robin arbiter.
//   clk, reset : clock, async active-high reset (pointer back to requester 0)
//   req        : request vector
//   advance    : a grant is being taken this cycle; move priority past winner
//   gnt        : one-hot grant (combinational)
module spi_rr_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);
  logic ptr;  // requester holding priority

  always_comb begin
    gnt = 2'b00;
    if (req[ptr])       gnt[ptr]  = 1'b1;
    else if (req[~ptr]) gnt[~ptr] = 1'b1;
  end

  // Winner 0 hands priority to 1 and vice versa.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                ptr <= 1'b0;
    else if (advance && |gnt) ptr <= gnt[0];
  end
endmodule

// File: rtl/spi_txn_scheduler.sv
// Schedules multi-byte SPI transactions from two requesters onto one byte
// engine.
//   clk, reset : clock, async active-high reset
//   bus        : requester handshake (req_valid/req_len/req_grant,
//                tx_data/tx_take), results (rx_data/rx_valid/rx_id,
//                txn_done/txn_err) and byte engine (eng_nwr/eng_data_tx,
//                eng_data_rx/eng_busy)
// Parameters: LEN_W byte-count field width, GAP_CYC inter-byte idle cycles,
// TO_CYC watchdog limit (>= 2) per byte, counted from LOAD.
module spi_txn_scheduler
  import spi_pkg::*;
#(
  parameter int LEN_W   = 4,
  parameter int GAP_CYC = GAP_CYC_DEF,
  parameter int TO_CYC  = TO_CYC_DEF
) (
  input logic                clk,
  input logic                reset,
  spi_txn_scheduler_if.slave bus
);
  localparam int WDW = $clog2(TO_CYC + 1);
  localparam int GW  = $clog2(GAP_CYC + 2);
  localparam logic [WDW-1:0] TO_LAST  = WDW'(TO_CYC - 1);
  localparam logic [GW-1:0]  GAP_LAST = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  state_t            state, state_n;
  logic [1:0]        gnt;
  logic              owner;
  logic [LEN_W-1:0]  cnt;
  logic [WDW-1:0]    wd;
  logic [GW-1:0]     gcnt;
  logic              eng_nwr;
  logic [BYTE_W-1:0] eng_data_tx;
  logic [BYTE_W-1:0] rx_data;
  logic              rx_valid, txn_done, txn_err;
  logic              in_wait, byte_end, progress, abort;

  spi_rr_arbiter u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (bus.req_valid),
    .advance (state == ARB),
    .gnt     (gnt)
  );

  assign in_wait  = (state == WAIT_BUSY) || (state == WAIT_DONE);
  assign byte_end = (state == WAIT_DONE) && !bus.eng_busy;
  // The engine answering on the last allowed cycle still counts as in time.
  assign progress = ((state == WAIT_BUSY) && bus.eng_busy) || byte_end;
  assign abort    = in_wait && (wd == TO_LAST) && !progress;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:      if (|bus.req_valid) state_n = ARB;
      ARB:       state_n = (|gnt) ? LOAD : IDLE;
      LOAD:      state_n = WAIT_BUSY;
      WAIT_BUSY: begin
        if (abort)             state_n = IDLE;
        else if (bus.eng_busy) state_n = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (abort)             state_n = IDLE;
        else if (byte_end)     state_n = (cnt == '0) ? IDLE :
                                         (GAP_CYC == 0) ? LOAD : GAP;
      end
      GAP:       if (gcnt == GAP_LAST) state_n = LOAD;
      default:   state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner       <= 1'b0;
      cnt         <= '0;
      wd          <= '0;
      gcnt        <= '0;
      eng_nwr     <= 1'b1;
      eng_data_tx <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      txn_done    <= 1'b0;
      txn_err     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      txn_done <= 1'b0;
      txn_err  <= 1'b0;
      unique case (state)
        ARB: begin
          if (|gnt) begin
            owner <= gnt[1];
            cnt   <= gnt[1] ? bus.req_len[2*LEN_W-1:LEN_W] : bus.req_len[LEN_W-1:0];
          end
        end
        LOAD: begin
          // Data and strobe change together so the engine sees a stable byte
          // at the falling edge of eng_nwr.
          eng_data_tx <= owner ? bus.tx_data[2*BYTE_W-1:BYTE_W] : bus.tx_data[BYTE_W-1:0];
          eng_nwr     <= 1'b0;
          wd          <= WDW'(1);  // the LOAD cycle itself counts toward the limit
        end
        WAIT_BUSY: begin
          wd <= wd + 1'b1;
          if (bus.eng_busy || abort) eng_nwr <= 1'b1;
          if (abort) txn_err <= 1'b1;
        end
        WAIT_DONE: begin
          wd <= wd + 1'b1;
          if (abort) txn_err <= 1'b1;
          if (byte_end) begin
            rx_data  <= bus.eng_data_rx;
            rx_valid <= 1'b1;
            gcnt     <= '0;
            if (cnt != '0) cnt <= cnt - 1'b1;
            else           txn_done <= 1'b1;
          end
        end
        GAP:     gcnt <= gcnt + 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.req_grant   = (state == ARB)  ? gnt : 2'b00;
  assign bus.tx_take     = (state == LOAD) ? {owner, ~owner} : 2'b00;
  assign bus.eng_nwr     = eng_nwr;
  assign bus.eng_data_tx = eng_data_tx;
  assign bus.rx_data     = rx_data;
  assign bus.rx_valid    = rx_valid;
  assign bus.rx_id       = owner;
  assign bus.txn_done    = txn_done;
  assign bus.txn_err     = txn_err;
endmodule
